fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream.sv | 100 ++++++++++
 tb/tb_fifo_rd_stream.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Pulls words out of a FIFO with a one-cycle read latency and presents them
// on a valid/ready stream. A 2-entry in-order buffer absorbs the read latency,
// so one word per cycle can be sustained while the sink keeps ready high.
//
// Ports
//   clk_i           sole clock, rising edge
//   rst_n_i         asynchronous active-low reset
//   enable_i        permits issuing new FIFO reads
//   fifo_empty_i    FIFO empty flag
//   fifo_rd_data_i  FIFO read data, valid the cycle after an accepted read
//   fifo_rd_req_o   FIFO read request (combinational)
//   src_data_o      stream data (head of the buffer)
//   src_valid_o     stream data valid
//   src_ready_i     downstream accepts data
//   word_cnt_o      count of delivered words, wraps
//   busy_o          a word is in flight or buffered
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 enable_i,
  input  logic                 fifo_empty_i,
  input  logic [WIDTH-1:0]     fifo_rd_data_i,
  output logic                 fifo_rd_req_o,
  output logic [WIDTH-1:0]     src_data_o,
  output logic                 src_valid_o,
  input  logic                 src_ready_i,
  output logic [CNT_WIDTH-1:0] word_cnt_o,
  output logic                 busy_o
);

  logic [1:0][WIDTH-1:0] buf_r;
  logic                  head_r;
  logic [1:0]            occ_r;
  logic                  inflight_r;
  logic [CNT_WIDTH-1:0]  cnt_r;

  logic                  pop_s;
  logic [2:0]            pend_s;
  logic                  rd_req_s;
  logic                  tail_s;
  logic [1:0]            occ_nxt_s;

  // Pop, read-issue and next-occupancy decode.
  always_comb begin
    pop_s     = 1'b0;
    pend_s    = 3'd0;
    rd_req_s  = 1'b0;
    tail_s    = 1'b0;
    occ_nxt_s = 2'd0;

    pop_s  = (occ_r != 2'd0) & src_ready_i;
    // Words that will still occupy the buffer after this cycle: buffered plus
    // in flight, less the one leaving now. A new read only fits below two.
    pend_s = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    // rst_n_i gates the request so it drops the moment reset asserts.
    if (rst_n_i && enable_i && !fifo_empty_i && (pend_s < 3'd2)) begin
      rd_req_s = 1'b1;
    end else begin
      rd_req_s = 1'b0;
    end
    // Tail slot is computed from the pre-pop head/occ, so a simultaneous pop
    // and arrival writes behind the departing head entry.
    tail_s    = head_r ^ occ_r[0];
    occ_nxt_s = occ_r + {1'b0, inflight_r} - {1'b0, pop_s};
  end

  // Buffer, pointers, in-flight flag and delivered-word counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      buf_r      <= '0;
      head_r     <= 1'b0;
      occ_r      <= 2'd0;
      inflight_r <= 1'b0;
      cnt_r      <= '0;
    end else begin
      inflight_r <= rd_req_s;
      occ_r      <= occ_nxt_s;
      head_r     <= head_r ^ pop_s;
      if (inflight_r) begin
        buf_r[tail_s] <= fifo_rd_data_i;
      end
      if (pop_s) begin
        cnt_r <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign fifo_rd_req_o = rd_req_s;
  assign src_valid_o   = (occ_r != 2'd0);
  assign src_data_o    = buf_r[head_r];
  assign busy_o        = (occ_r != 2'd0) | inflight_r;
  assign word_cnt_o    = cnt_r;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
// Directed bench for fifo_rd_stream with a behavioural one-cycle-latency FIFO.
// Runs with CNT_WIDTH=4 so counter wrap is reachable.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       enable_i;
  logic       fifo_empty_i;
  logic [3:0] fifo_rd_data_i = 4'h0;
  logic       fifo_rd_req_o;
  logic [3:0] src_data_o;
  logic       src_valid_o;
  logic       src_ready_i;
  logic [3:0] word_cnt_o;
  logic       busy_o;

  logic [3:0] mem [64];
  logic [5:0] wp = 6'd0;
  logic [5:0] rp = 6'd0;
  int         n_reads = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         r0;
  int         k;
  logic [3:0] exp_w [17];

  fifo_rd_stream #(.WIDTH(4), .CNT_WIDTH(4)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .enable_i       (enable_i),
    .fifo_empty_i   (fifo_empty_i),
    .fifo_rd_data_i (fifo_rd_data_i),
    .fifo_rd_req_o  (fifo_rd_req_o),
    .src_data_o     (src_data_o),
    .src_valid_o    (src_valid_o),
    .src_ready_i    (src_ready_i),
    .word_cnt_o     (word_cnt_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  assign fifo_empty_i = (rp == wp);

  // Behavioural FIFO: read data appears the cycle after an accepted request.
  always @(posedge clk_i) begin
    if (fifo_rd_req_o) begin
      fifo_rd_data_i <= mem[rp];
      rp             <= rp + 6'd1;
      n_reads        <= n_reads + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] v);
    mem[wp] = v;
    wp = wp + 6'd1;
  endtask

  initial begin
    rst_n_i     = 1'b0;
    enable_i    = 1'b1;
    src_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) push(4'(i));

    // Reset: outputs low even with enable and a non-empty FIFO.
    repeat (2) @(negedge clk_i);
    check("rst_req",   {31'd0, fifo_rd_req_o}, 32'd0);
    check("rst_valid", {31'd0, src_valid_o},   32'd0);
    check("rst_busy",  {31'd0, busy_o},        32'd0);
    check("rst_cnt",   {28'd0, word_cnt_o},    32'd0);
    check("rst_data",  {28'd0, src_data_o},    32'd0);
    enable_i = 1'b0;
    rst_n_i  = 1'b1;
    @(negedge clk_i);

    // Streaming 0x1..0x8: first valid two cycles after the first request.
    enable_i = 1'b1;
    #1 check("stream_req", {31'd0, fifo_rd_req_o}, 32'd1);
    @(negedge clk_i);
    check("stream_lat_valid", {31'd0, src_valid_o}, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_i);
      check("stream_valid", {31'd0, src_valid_o}, 32'd1);
      check("stream_data",  {28'd0, src_data_o},  32'(i));
    end
    enable_i = 1'b0;
    @(negedge clk_i);
    check("stream_end_valid", {31'd0, src_valid_o}, 32'd0);
    check("stream_end_busy",  {31'd0, busy_o},      32'd0);
    check("stream_cnt",       {28'd0, word_cnt_o},  32'd8);
    check("stream_reads",     32'(n_reads),         32'd8);

    // Backpressure: only two reads fit, head held stable.
    src_ready_i = 1'b0;
    push(4'hA); push(4'hB); push(4'hC);
    r0 = n_reads;
    enable_i = 1'b1;
    @(negedge clk_i);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("bp_valid", {31'd0, src_valid_o}, 32'd1);
      check("bp_hold",  {28'd0, src_data_o},  32'hA);
    end
    check("bp_reads", 32'(n_reads - r0), 32'd2);
    src_ready_i = 1'b1;
    #1 check("bp_pop_a", {28'd0, src_data_o}, 32'hA);
    @(negedge clk_i);
    check("bp_pop_b", {28'd0, src_data_o}, 32'hB);
    @(negedge clk_i);
    check("bp_pop_c", {28'd0, src_data_o}, 32'hC);
    @(negedge clk_i);
    check("bp_end_valid", {31'd0, src_valid_o}, 32'd0);
    check("bp_cnt",       {28'd0, word_cnt_o},  32'd11);

    // Empty FIFO with enable high: nothing happens.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("empty_req",   {31'd0, fifo_rd_req_o}, 32'd0);
      check("empty_valid", {31'd0, src_valid_o},   32'd0);
      check("empty_cnt",   {28'd0, word_cnt_o},    32'd11);
    end
    check("empty_reads", 32'(n_reads - r0), 32'd3);

    // Enable drop right after a read issues.
    enable_i = 1'b0;
    push(4'hD); push(4'hE);
    r0 = n_reads;
    @(negedge clk_i);
    enable_i = 1'b1;
    #1 check("drop_req_on", {31'd0, fifo_rd_req_o}, 32'd1);
    @(negedge clk_i);
    enable_i = 1'b0;
    #1 check("drop_req_off", {31'd0, fifo_rd_req_o}, 32'd0);
    check("drop_busy", {31'd0, busy_o}, 32'd1);
    @(negedge clk_i);
    check("drop_valid", {31'd0, src_valid_o}, 32'd1);
    check("drop_data",  {28'd0, src_data_o},  32'hD);
    @(negedge clk_i);
    check("drop_end_busy", {31'd0, busy_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    check("drop_reads", 32'(n_reads - r0), 32'd1);
    check("drop_cnt",   {28'd0, word_cnt_o}, 32'd12);

    // Reset mid-stream with a full buffer: outputs clear before any edge.
    push(4'h5); push(4'h6);
    src_ready_i = 1'b0;
    enable_i    = 1'b1;
    repeat (5) @(negedge clk_i);
    check("mid_valid", {31'd0, src_valid_o}, 32'd1);
    check("mid_data",  {28'd0, src_data_o},  32'hE);
    check("mid_busy",  {31'd0, busy_o},      32'd1);
    #2 rst_n_i = 1'b0;
    #1;
    check("arst_valid", {31'd0, src_valid_o},   32'd0);
    check("arst_busy",  {31'd0, busy_o},        32'd0);
    check("arst_cnt",   {28'd0, word_cnt_o},    32'd0);
    check("arst_req",   {31'd0, fifo_rd_req_o}, 32'd0);
    check("arst_data",  {28'd0, src_data_o},    32'd0);
    @(negedge clk_i);
    rst_n_i     = 1'b1;
    enable_i    = 1'b0;
    src_ready_i = 1'b1;
    @(negedge clk_i);
    check("post_rst_valid", {31'd0, src_valid_o}, 32'd0);

    // Counter wrap: 0x6 left in the FIFO plus 16 more words = 17 delivered.
    exp_w[0] = 4'h6;
    for (int i = 0; i < 16; i++) begin
      push(4'(i * 3 + 1));
      exp_w[i + 1] = 4'(i * 3 + 1);
    end
    enable_i = 1'b1;
    k = 0;
    for (int cyc = 0; cyc < 60 && k < 17; cyc++) begin
      @(negedge clk_i);
      if (src_valid_o) begin
        check("wrap_data", {28'd0, src_data_o}, {28'd0, exp_w[k]});
        k++;
      end
    end
    check("wrap_words", 32'(k), 32'd17);
    repeat (2) @(negedge clk_i);
    check("wrap_cnt",  {28'd0, word_cnt_o}, 32'd1);
    check("wrap_busy", {31'd0, busy_o},     32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
